vga_pixel_reader: RTL and testbench
===================================

# vga_pixel_reader

Consumer-side engine for the pixel line FIFO. It drains words from the FIFO's read port (`rd` / `rd_data` / `empty`) and presents one pixel per VGA timing request, absorbing the FIFO's one-cycle read latency with a 2-entry prefetch buffer. It tracks pixel and line position across a frame and flags underruns. It sits between the pixel FIFO and the VGA output stage.

## Interface
- `B`, 8: pixel/data width; must match the FIFO data width.
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `UNDERRUN_PIX`, 0: value driven on `pix_data` for a starved request.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse at the start of each frame.
- `pix_req`  in  1  VGA stage needs one active pixel this cycle.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_data`  in  B  FIFO read data, valid the cycle after an accepted read.
- `fifo_rd`  out  1  FIFO read strobe (combinational from registered state).
- `pix_data`  out  B  registered pixel.
- `pix_valid`  out  1  `pix_data` corresponds to a `pix_req` in the previous cycle.
- `x_cnt`  out  $clog2(H_ACTIVE)  pixel index of the last delivered pixel.
- `y_cnt`  out  $clog2(V_ACTIVE)  line index of the last delivered pixel.
- `underrun`  out  1  sticky; set on a starved request, cleared by `frame_start`.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame.
- `frame_err`  out  1  one-cycle pulse on `frame_start` outside IDLE.
- `underrun_cnt`  out  16  saturating underrun count (see Configuration).

## Operation
- States:
  - IDLE: no reads issued. `frame_start` moves to PRIME.
  - PRIME: fetch until the buffer holds 2 entries, then move to STREAM.
  - STREAM: serve requests.
- Buffer bookkeeping:
  - `occ` (0..2) counts held entries. `inflight` (0..1) is a registered copy of `fifo_rd && !fifo_empty`.
  - An in-flight word is captured from `fifo_rd_data` into the buffer tail on the following cycle.
- Pop: `pop = pix_req && occ > 0`.
- `fifo_rd = (state != IDLE) && !fifo_empty && (occ + inflight - pop) < 2`. This sustains one pixel per cycle.
- Served request (pop): `pix_data <=` buffer head, `pix_valid <= 1`, advance `x_cnt`/`y_cnt`.
- Starved request (`pix_req && occ == 0`), in PRIME or STREAM:
  - `pix_data <= UNDERRUN_PIX`, `pix_valid <= 1`.
  - Set `underrun`; counters still advance so screen position is preserved.
- `pix_req` in IDLE is ignored: `pix_valid` is 0 and counters are held.
- Counters:
  - `x_cnt` wraps `H_ACTIVE-1 -> 0` and increments `y_cnt`.
  - On the pixel at (`H_ACTIVE-1`, `V_ACTIVE-1`): pulse `frame_done` next cycle, clear both counters, go to IDLE. Buffer contents are retained.
- `frame_start` in PRIME/STREAM:
  - Pulse `frame_err`, clear counters and `underrun`, enter PRIME.
  - Buffer and any in-flight read are retained.
- `frame_start` coincident with a request: the request is served first, then counters clear.

## Timing
- Latency: `pix_req` at cycle t gives `pix_data`/`pix_valid` at t+1.
- FIFO read: read accepted at t, data captured at t+1, earliest use by a `pix_req` at t+1.
- Priming from IDLE with a non-empty FIFO: PRIME entered at t+1. `fifo_rd` is high at t+1 and t+2; STREAM is entered at t+4.
- Reset values: state IDLE, `occ`=0, `inflight`=0, `fifo_rd`=0, `pix_data`=0, `pix_valid`=0, `x_cnt`=0, `y_cnt`=0, `underrun`=0, `frame_done`=0, `frame_err`=0, `underrun_cnt`=0.
- Reset mid-frame discards buffer contents. An in-flight word is dropped.
- `fifo_rd` is never asserted while `fifo_empty` is high.

## Configuration
- `PIXEL_READER_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` increments on each starved request and saturates at 16'hFFFF.
  - It clears only on reset, not on `frame_start`.
- Not defined: `underrun_cnt` is tied to 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- Reset, FIFO preloaded with 0x10..0x1F, `frame_start`: reads issued at cycles 1–2, STREAM at cycle 4. Continuous `pix_req` yields 0x10, 0x11, … on consecutive cycles with no gaps and `underrun`=0.
- Continuous `pix_req` with the FIFO going empty after 3 words: outputs 0x10, 0x11, 0x12 then `UNDERRUN_PIX`. `underrun`=1, `x_cnt` keeps advancing, `underrun_cnt`=1 with the macro and 0 without.
- `H_ACTIVE`=4, `V_ACTIVE`=2, 8 requests: `x_cnt` sequence 0..3,0..3; `y_cnt` goes 0→1; `frame_done` pulses once after the 8th pixel; state returns to IDLE.
- `frame_start` at pixel 5 of a frame: `frame_err` pulse, counters reset to 0, next pixel served from the retained buffer without data loss.
- `rst_n` low for 1 cycle mid-STREAM: all outputs take their reset values next cycle, `fifo_rd`=0 until the next `frame_start`.
- Macro build, 70000 forced underruns: `underrun_cnt` saturates at 0xFFFF.

Source files
------------

// File: rtl/vga_pixel_reader.sv
// vga_pixel_reader
// Consumer side of the pixel line FIFO. It pulls words through a 2-entry
// prefetch buffer that hides the FIFO's one-cycle read latency. It returns one
// registered pixel per VGA request and tracks screen position and underruns.
//
// Build option: define PIXEL_READER_UNDERRUN_CNT_EN to generate the saturating
// 16-bit underrun counter. Without it, underrun_cnt is tied to zero.
//
// Handshake rules:
//   FIFO side
//     A read is accepted in any cycle where fifo_rd && !fifo_empty.
//     The accepted word appears on fifo_rd_data in the next cycle, and is
//     written into the buffer tail at the end of that cycle.
//     fifo_rd is never raised while fifo_empty is high.
//   VGA side
//     pix_req is a demand with no back-pressure.
//     Every request seen in PRIME or STREAM produces pix_valid one cycle later.
//     If the buffer was empty, the pixel is UNDERRUN_PIX.
//
// x_cnt / y_cnt report the screen position of the pixel currently on
// pix_data. The internal next-position counters (nx / ny) are what wrap at
// the end of a frame and clear on frame_start.
//
// dbg_state exposes the FSM: 0 = IDLE, 1 = PRIME, 2 = STREAM.

module vga_pixel_reader #(
  parameter int             B            = 8,
  parameter int             H_ACTIVE     = 640,
  parameter int             V_ACTIVE     = 480,
  parameter logic [B-1:0]   UNDERRUN_PIX = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        pix_req,
  input  logic                        fifo_empty,
  input  logic [B-1:0]                fifo_rd_data,
  output logic                        fifo_rd,
  output logic [B-1:0]                pix_data,
  output logic                        pix_valid,
  output logic [$clog2(H_ACTIVE)-1:0] x_cnt,
  output logic [$clog2(V_ACTIVE)-1:0] y_cnt,
  output logic                        underrun,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic [15:0]                 underrun_cnt,
  output logic [1:0]                  dbg_state
);

  localparam int            XW     = $clog2(H_ACTIVE);
  localparam int            YW     = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Prefetch buffer: buf0 is the head, buf1 the tail.
  logic [B-1:0]  buf0;
  logic [B-1:0]  buf1;
  logic [B-1:0]  buf0_nxt;
  logic [B-1:0]  buf1_nxt;
  logic [1:0]    occ;
  logic [1:0]    occ_nxt;
  logic          inflight;

  // Position of the next pixel to be delivered.
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  logic          active;
  logic          pop;
  logic          starve;
  logic          serve;
  logic          last_pix;
  logic [2:0]    level;
  logic [1:0]    hold;

  assign dbg_state = state;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state.
  // frame_start wins over end-of-frame, so a restart never falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nxt = S_PRIME;
        end
      end
      S_PRIME: begin
        if (frame_start) begin
          state_nxt = S_PRIME;
        end else if (serve && last_pix) begin
          state_nxt = S_IDLE;
        end else if (occ_nxt == 2'd2) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (frame_start) begin
          state_nxt = S_PRIME;
        end else if (serve && last_pix) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request classification and the FIFO read strobe.
  // level is the buffer fill once this cycle's pop and capture are applied.
  always_comb begin
    active   = (state != S_IDLE);
    pop      = active && pix_req && (occ != 2'd0);
    starve   = active && pix_req && (occ == 2'd0);
    serve    = pop || starve;
    last_pix = (nx == X_LAST) && (ny == Y_LAST);
    level    = 3'(occ) + 3'(inflight) - 3'(pop);
    hold     = occ - 2'(pop);
    occ_nxt  = level[1:0];
    fifo_rd  = active && !fifo_empty && (level < 3'd2);
  end

  // Next buffer contents.
  // Shift on pop, then drop any arriving word into the first free slot.
  always_comb begin
    buf0_nxt = buf0;
    buf1_nxt = buf1;
    if (pop) begin
      buf0_nxt = buf1;
    end
    if (inflight) begin
      if (hold == 2'd0) begin
        buf0_nxt = fifo_rd_data;
      end else begin
        buf1_nxt = fifo_rd_data;
      end
    end
  end

  // Buffer, occupancy and in-flight tracking.
  // All of it is discarded on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf0     <= '0;
      buf1     <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      buf0     <= buf0_nxt;
      buf1     <= buf1_nxt;
      occ      <= occ_nxt;
      inflight <= fifo_rd && !fifo_empty;
    end
  end

  // Next-pixel position.
  // Advances on every delivered pixel, starved or not, wraps at end of frame,
  // and restarts on frame_start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nx <= '0;
      ny <= '0;
    end else if (frame_start) begin
      nx <= '0;
      ny <= '0;
    end else if (serve) begin
      if (nx == X_LAST) begin
        nx <= '0;
        ny <= (ny == Y_LAST) ? '0 : ny + YW'(1);
      end else begin
        nx <= nx + XW'(1);
      end
    end
  end

  // Registered pixel outputs and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pix_valid  <= serve;
      frame_done <= serve && last_pix;
      frame_err  <= frame_start && active;

      if (pop) begin
        pix_data <= buf0;
      end else if (starve) begin
        pix_data <= UNDERRUN_PIX;
      end

      // A request coincident with frame_start is reported at its old position.
      if (serve) begin
        x_cnt <= nx;
        y_cnt <= ny;
      end else if (frame_start) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end

      if (frame_start) begin
        underrun <= 1'b0;
      end else if (starve) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef PIXEL_READER_UNDERRUN_CNT_EN
  // Lifetime underrun count.
  // It saturates at all-ones and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_cnt <= 16'd0;
    end else if (starve && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_pixel_reader.sv
// tb_vga_pixel_reader
// Drives vga_pixel_reader from a queue-based FIFO model.
// Every cycle is compared against a transaction-level reference:
//   - the prefetch buffer and the FIFO are queues of words;
//   - screen position is a single linear pixel index.
// Directed sequences come first, then a randomized run.
// The saturation test runs only when PIXEL_READER_UNDERRUN_CNT_EN is defined.

module tb_vga_pixel_reader;

  localparam int             B    = 8;
  localparam int             H    = 4;
  localparam int             V    = 2;
  localparam logic [B-1:0]   UPIX = 8'hEE;
  localparam int             XW   = $clog2(H);
  localparam int             YW   = $clog2(V);

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          frame_start;
  logic          pix_req;
  logic          fifo_empty;
  logic [B-1:0]  fifo_rd_data;
  logic          fifo_rd;
  logic [B-1:0]  pix_data;
  logic          pix_valid;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          underrun;
  logic          frame_done;
  logic          frame_err;
  logic [15:0]   underrun_cnt;
  logic [1:0]    dbg_state;

  vga_pixel_reader #(
    .B            (B),
    .H_ACTIVE     (H),
    .V_ACTIVE     (V),
    .UNDERRUN_PIX (UPIX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .pix_req      (pix_req),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .x_cnt        (x_cnt),
    .y_cnt        (y_cnt),
    .underrun     (underrun),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .underrun_cnt (underrun_cnt),
    .dbg_state    (dbg_state)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  // States: 0 idle, 1 priming, 2 streaming.
  int           m_state    = 0;
  logic [B-1:0] pre_q[$];
  bit           m_inf      = 1'b0;
  logic [B-1:0] m_inf_word = '0;
  int           m_pos      = 0;
  bit           m_underrun = 1'b0;
  int           m_ucnt     = 0;
  logic [B-1:0] e_pix      = '0;
  bit           e_valid    = 1'b0;
  bit           e_done     = 1'b0;
  bit           e_err      = 1'b0;
  int           e_x        = 0;
  int           e_y        = 0;

  logic [B-1:0] fifo_q[$];
  logic [B-1:0] exp_q[$];
  bit           chk_en   = 1'b1;
  bit           seen_rd  = 1'b0;
  int           done_cnt = 0;

  // One clock cycle.
  // Inputs are applied just after the rising edge.
  // fifo_rd is checked on the falling edge.
  // Registered outputs are checked 1 time unit after the next rising edge.
  task automatic step(input bit req, input bit fs, input bit rstn);
    bit           exp_rd;
    bit           pop;
    bit           starve;
    bit           serve;
    bit           last;
    bit           dut_rd;
    int           occ;
    logic [B-1:0] nxt_word;

    pix_req     = req;
    frame_start = fs;
    rst_n       = rstn;
    fifo_empty  = (fifo_q.size() == 0);

    @(negedge clk);
    occ      = pre_q.size();
    pop      = (m_state != 0) && req && (occ > 0);
    starve   = (m_state != 0) && req && (occ == 0);
    exp_rd   = (m_state != 0) && !fifo_empty && ((occ + int'(m_inf) - int'(pop)) < 2);
    nxt_word = '0;
    if (exp_rd) nxt_word = fifo_q[0];
    seen_rd  = fifo_rd;
    dut_rd   = (fifo_rd === 1'b1) && !fifo_empty;
    if (chk_en) begin
      check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
      check("rd_while_empty", 32'(fifo_rd && fifo_empty), 32'd0);
    end

    @(posedge clk);
    if (!rstn) begin
      m_state    = 0;
      pre_q.delete();
      m_inf      = 1'b0;
      m_pos      = 0;
      m_underrun = 1'b0;
      m_ucnt     = 0;
      e_pix      = '0;
      e_valid    = 1'b0;
      e_done     = 1'b0;
      e_err      = 1'b0;
      e_x        = 0;
      e_y        = 0;
    end else begin
      serve   = pop || starve;
      last    = (m_pos == H * V - 1);
      e_valid = serve;
      e_done  = serve && last;
      e_err   = fs && (m_state != 0);
      if (pop) e_pix = pre_q.pop_front();
      else if (starve) e_pix = UPIX;
      if (serve) begin
        e_x   = m_pos % H;
        e_y   = m_pos / H;
        m_pos = last ? 0 : m_pos + 1;
      end else if (fs) begin
        e_x = 0;
        e_y = 0;
      end
`ifdef PIXEL_READER_UNDERRUN_CNT_EN
      if (starve && (m_ucnt < 65535)) m_ucnt++;
`endif
      if (m_inf) pre_q.push_back(m_inf_word);
      m_inf      = exp_rd;
      m_inf_word = nxt_word;
      if (fs) m_underrun = 1'b0;
      else if (starve) m_underrun = 1'b1;
      if (fs) begin
        m_pos   = 0;
        m_state = 1;
      end else if ((m_state != 0) && serve && last) begin
        m_state = 0;
      end else if ((m_state == 1) && (pre_q.size() == 2)) begin
        m_state = 2;
      end
    end

    #1;
    if (dut_rd) fifo_rd_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    if (frame_done === 1'b1) done_cnt++;
    if (e_valid) exp_q.push_back(e_pix);
    if (chk_en) begin
      check("pix_valid",    32'(pix_valid),    32'(e_valid));
      check("frame_done",   32'(frame_done),   32'(e_done));
      check("frame_err",    32'(frame_err),    32'(e_err));
      check("x_cnt",        32'(x_cnt),        32'(e_x));
      check("y_cnt",        32'(y_cnt),        32'(e_y));
      check("underrun",     32'(underrun),     32'(m_underrun));
      check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
      check("state",        32'(dbg_state),    32'(m_state));
      if (!rstn) check("pix_data_rst", 32'(pix_data), 32'd0);
    end
    if (e_valid && (exp_q.size() > 0)) begin
      logic [B-1:0] want;
      want = exp_q.pop_front();
      if (chk_en) check("pix_data", 32'(pix_data), 32'(want));
    end
  endtask

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pix_req      = 1'b0;
    frame_start  = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;

    // Reset: the first cycle has undefined DUT state, so it is not compared.
    chk_en = 1'b0;
    step(0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0);
    check("rst_fifo_rd",   32'(fifo_rd),   32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    step(0, 0, 1);

    // Priming: reads issued in cycles 1-2, STREAM entered in cycle 4.
    // Then one full 4x2 frame is read at one pixel per cycle.
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h10 + i));
    step(0, 1, 1);
    step(0, 0, 1);
    check("prime_rd_c1", 32'(seen_rd), 32'd1);
    step(0, 0, 1);
    check("prime_rd_c2", 32'(seen_rd), 32'd1);
    step(0, 0, 1);
    check("prime_rd_c3", 32'(seen_rd), 32'd0);
    check("stream_at_c4", 32'(dbg_state), 32'd2);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1);
      check("t1_pix",  32'(pix_data),  32'(8'h10 + i));
      check("t1_x",    32'(x_cnt),     32'(i % 4));
      check("t1_y",    32'(y_cnt),     32'(i / 4));
      check("t1_done", 32'(frame_done), 32'(i == 7));
      check("t1_urun", 32'(underrun),  32'd0);
    end
    step(0, 0, 1);
    check("t1_done_once", 32'(done_cnt),  32'd1);
    check("t1_idle",      32'(dbg_state), 32'd0);

    // Underrun: the FIFO holds only three words.
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'(8'h10 + i));
    step(0, 1, 1);
    repeat (3) step(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1);
      check("t2_pix", 32'(pix_data), (i < 3) ? 32'(8'h10 + i) : 32'(UPIX));
      check("t2_x",   32'(x_cnt),    32'(i));
    end
    check("t2_urun", 32'(underrun), 32'd1);
`ifdef PIXEL_READER_UNDERRUN_CNT_EN
    check("t2_ucnt", 32'(underrun_cnt), 32'd1);
`else
    check("t2_ucnt", 32'(underrun_cnt), 32'd0);
`endif

    // One-cycle reset in the middle of STREAM.
    step(1, 0, 0);
    check("t5_valid", 32'(pix_valid), 32'd0);
    check("t5_pix",   32'(pix_data),  32'd0);
    check("t5_urun",  32'(underrun),  32'd0);
    check("t5_state", 32'(dbg_state), 32'd0);
    fifo_q.push_back(8'h20);
    fifo_q.push_back(8'h21);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1);
      check("t5_no_rd", 32'(seen_rd),   32'd0);
      check("t5_idle",  32'(pix_valid), 32'd0);
    end

    // Restart at pixel 5: the retained buffer keeps its order.
    for (int i = 2; i < 8; i++) fifo_q.push_back(8'(8'h20 + i));
    step(0, 1, 1);
    repeat (3) step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1);
      check("t4_pix", 32'(pix_data), 32'(8'h20 + i));
    end
    step(0, 1, 1);
    check("t4_err",   32'(frame_err), 32'd1);
    check("t4_x",     32'(x_cnt),     32'd0);
    check("t4_y",     32'(y_cnt),     32'd0);
    check("t4_state", 32'(dbg_state), 32'd1);
    step(1, 0, 1);
    check("t4_next_pix", 32'(pix_data),  32'h25);
    check("t4_next_x",   32'(x_cnt),     32'd0);
    check("t4_next_val", 32'(pix_valid), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit r_req;
      bit r_fs;
      bit r_rstn;
      if ((fifo_q.size() < 12) && ($urandom_range(0, 1) == 1)) fifo_q.push_back(8'($urandom));
      r_req  = ($urandom_range(0, 9) < 7);
      r_fs   = (m_state == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      r_rstn = ($urandom_range(0, 999) != 0);
      step(r_req, r_fs, r_rstn);
    end

`ifdef PIXEL_READER_UNDERRUN_CNT_EN
    // Saturation: a restart on every cycle with an empty FIFO starves every request.
    fifo_q.delete();
    step(0, 0, 0);
    step(0, 1, 1);
    chk_en = 1'b0;
    repeat (70000) step(1, 1, 1);
    chk_en = 1'b1;
    check("sat_ucnt", 32'(underrun_cnt), 32'h0000FFFF);
    step(1, 1, 1);
    check("sat_hold", 32'(underrun_cnt), 32'h0000FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
